// File: rtl/pc_unit_p_if.sv
// Control-unit op encoding and the PC unit bus interface.
// Counter signals exist only when PC_PERF_COUNT_EN is defined.
package pc_unit_p_pkg;
   typedef enum logic [5:0] {
      CU_NOP   = 6'h00,
      CU_ADD   = 6'h01,
      CU_SUB   = 6'h02,
      CU_AND   = 6'h03,
      CU_OR    = 6'h04,
      CU_XOR   = 6'h05,
      CU_SLL   = 6'h06,
      CU_SRL   = 6'h07,
      CU_SRA   = 6'h08,
      CU_SLT   = 6'h09,
      CU_SLTU  = 6'h0A,
      CU_LUI   = 6'h0B,
      CU_AUIPC = 6'h0C,
      CU_LOAD  = 6'h0D,
      CU_STORE = 6'h0E,
      CU_JAL   = 6'h10,
      CU_JALR  = 6'h11,
      CU_BEQ   = 6'h18,
      CU_BNE   = 6'h19,
      CU_BLT   = 6'h1A,
      CU_BGE   = 6'h1B,
      CU_BLTU  = 6'h1C,
      CU_BGEU  = 6'h1D,
      CU_ERROR = 6'h3F
   } cuop_t;
endpackage

interface pc_unit_p_if #(
   parameter int XLEN = 32
`ifdef PC_PERF_COUNT_EN
   ,
   parameter int CNT_W = 32
`endif
);
   import pc_unit_p_pkg::*;

   cuop_t            cuOP;
   logic [XLEN-1:0]  rs1Read;
   logic [XLEN-1:0]  signExtend;
   logic             Zero;
   logic             ALUneg;
   logic             ALUltu;
   logic             iready;
   logic             trapAck;
   logic [XLEN-1:0]  PCaddr;
   logic [XLEN-1:0]  PClink;
   logic             pcValid;
   logic             trapActive;
   logic [1:0]       trapCause;
   logic [XLEN-1:0]  trapValue;
`ifdef PC_PERF_COUNT_EN
   logic [CNT_W-1:0] instrCount;
   logic [CNT_W-1:0] takenCount;
`endif

   modport master (
      output cuOP, rs1Read, signExtend, Zero, ALUneg, ALUltu, iready, trapAck,
      input  PCaddr, PClink, pcValid, trapActive, trapCause, trapValue
`ifdef PC_PERF_COUNT_EN
      , input instrCount, takenCount
`endif
   );

   modport slave (
      input  cuOP, rs1Read, signExtend, Zero, ALUneg, ALUltu, iready, trapAck,
      output PCaddr, PClink, pcValid, trapActive, trapCause, trapValue
`ifdef PC_PERF_COUNT_EN
      , output instrCount, takenCount
`endif
   );
endinterface

// File: rtl/pc_unit_p.sv
// Program counter with boot/run/trap sequencing for the single-cycle core.
// Optional PC_PERF_COUNT_EN adds retired-instruction and taken-jump counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_BOOT | one cycle after reset, PCaddr = RESET_VECTOR, not yet valid
// ST_RUN  | normal sequencing, PC advances on iready
// ST_TRAP | parked at TRAP_VECTOR until trapAck
module pc_unit_p #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int              IALIGN       = 4
`ifdef PC_PERF_COUNT_EN
   ,
   parameter int              CNT_W        = 32
`endif
) (
   input  logic         i_clk,
   input  logic         i_rst,
   pc_unit_p_if.slave   bus
);
   import pc_unit_p_pkg::*;

   localparam int LP_AW = $clog2(IALIGN);

   typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_TRAP} state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_trap_value;
   logic [1:0]        r_trap_cause;
   logic              r_pc_valid;
   logic              r_trap_active;

   logic [XLEN-1:0]   w_pc_seq;
   logic [XLEN-1:0]   w_pc_rel;
   logic [XLEN-1:0]   w_jalr_sum;
   logic [XLEN-1:0]   w_target;
   logic              w_take;
   logic              w_is_jalr;
   logic              w_misaligned;
   logic              w_illegal;

   assign w_pc_seq   = r_pc + XLEN'(4);
   assign w_pc_rel   = r_pc + bus.signExtend;
   assign w_jalr_sum = bus.rs1Read + bus.signExtend;
   assign w_illegal  = (bus.cuOP == CU_ERROR);

   always_comb begin
      w_take    = 1'b0;
      w_is_jalr = 1'b0;
      case (bus.cuOP)
         CU_JAL:  w_take = 1'b1;
         CU_JALR: begin
            w_take    = 1'b1;
            w_is_jalr = 1'b1;
         end
         CU_BEQ:  w_take = bus.Zero;
         CU_BNE:  w_take = !bus.Zero;
         CU_BLT:  w_take = bus.ALUneg;
         CU_BGE:  w_take = !bus.ALUneg || bus.Zero;
         CU_BLTU: w_take = bus.ALUltu;
         CU_BGEU: w_take = !bus.ALUltu || bus.Zero;
         default: w_take = 1'b0;
      endcase
   end

   always_comb begin
      w_target = w_pc_seq;
      if (w_is_jalr)
         w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
      else if (w_take)
         w_target = w_pc_rel;
   end

   // Only taken control transfers are alignment-checked; JALR bit0 is already clear.
   assign w_misaligned = w_take && (w_target[LP_AW-1:0] != '0);

`ifdef PC_PERF_COUNT_EN
   logic [CNT_W-1:0] r_instr_cnt;
   logic [CNT_W-1:0] r_taken_cnt;
   assign bus.instrCount = r_instr_cnt;
   assign bus.takenCount = r_taken_cnt;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= ST_BOOT;
         r_pc          <= RESET_VECTOR;
         r_pc_valid    <= 1'b0;
         r_trap_active <= 1'b0;
         r_trap_cause  <= 2'b00;
         r_trap_value  <= '0;
`ifdef PC_PERF_COUNT_EN
         r_instr_cnt   <= '0;
         r_taken_cnt   <= '0;
`endif
      end else begin
         case (r_state)
            ST_BOOT: begin
               r_state    <= ST_RUN;
               r_pc_valid <= 1'b1;
            end
            ST_RUN: begin
               if (bus.iready) begin
`ifdef PC_PERF_COUNT_EN
                  r_instr_cnt <= r_instr_cnt + CNT_W'(1);
`endif
                  if (w_illegal) begin
                     r_state       <= ST_TRAP;
                     r_pc          <= TRAP_VECTOR;
                     r_pc_valid    <= 1'b0;
                     r_trap_active <= 1'b1;
                     r_trap_cause  <= 2'b10;
                     r_trap_value  <= r_pc;
                  end else if (w_misaligned) begin
                     r_state       <= ST_TRAP;
                     r_pc          <= TRAP_VECTOR;
                     r_pc_valid    <= 1'b0;
                     r_trap_active <= 1'b1;
                     r_trap_cause  <= 2'b01;
                     r_trap_value  <= w_target;
                  end else begin
                     r_pc <= w_target;
`ifdef PC_PERF_COUNT_EN
                     if (w_take)
                        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
`endif
                  end
               end
            end
            ST_TRAP: begin
               // Cause and value stay sticky after ack so the handler can read them.
               if (bus.trapAck) begin
                  r_state       <= ST_RUN;
                  r_pc_valid    <= 1'b1;
                  r_trap_active <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_BOOT;
               r_pc       <= RESET_VECTOR;
               r_pc_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.PCaddr     = r_pc;
   assign bus.PClink     = w_pc_seq;
   assign bus.pcValid    = r_pc_valid;
   assign bus.trapActive = r_trap_active;
   assign bus.trapCause  = r_trap_cause;
   assign bus.trapValue  = r_trap_value;

endmodule

// File: doc/pc_unit_p.md
Name: pc_unit_p

Overview:
Parametrised next-generation program counter for the single-cycle RISC-V core. It sits between the control unit/ALU and instruction memory, and owns PC sequencing for all cuOP classes. It adds the following over the current PC:
- configurable width, reset vector and alignment
- a separate unsigned-compare flag, so BLTU/BGEU resolve correctly
- a boot state and a trap state machine for misaligned targets and CU_ERROR
- a link-address output

Parameters:
XLEN, 32, datapath/PC width in bits
RESET_VECTOR, 32'h0000_0000, PCaddr value after reset
TRAP_VECTOR, 32'h0000_0100, PCaddr loaded on any trap
IALIGN, 4, required target alignment in bytes; legal values 2 or 4
CNT_W, 32, width of performance counters (used only with PC_PERF_COUNT_EN)

Ports:
clk  in  1  system clock, all state on rising edge
RST  in  1  synchronous active-high reset
cuOP  in  6 (cuOPType)  decoded operation from control unit
rs1Read  in  XLEN  rs1 register value (JALR base)
signExtend  in  XLEN  sign-extended immediate
Zero  in  1  ALU result zero (rs1 == rs2)
ALUneg  in  1  signed rs1 < rs2
ALUltu  in  1  unsigned rs1 < rs2
iready  in  1  current instruction valid; PC may advance only when high
trapAck  in  1  trap handler acknowledge; single-cycle pulse
PCaddr  out  XLEN  current fetch address
PClink  out  XLEN  PCaddr + 4 (combinational), rd value for JAL/JALR
pcValid  out  1  PCaddr is a legal fetch address
trapActive  out  1  block is in TRAP state
trapCause  out  2  00 none, 01 misaligned target, 10 illegal op (CU_ERROR)
trapValue  out  XLEN  offending target address, or PCaddr of the illegal op

Behaviour:
- Reset (RST=1 at clk edge, overrides everything, including mid-trap):
  - state=BOOT, PCaddr=RESET_VECTOR, pcValid=0, trapActive=0, trapCause=00, trapValue=0.
- States: BOOT, RUN, TRAP.
- BOOT:
  - exactly one cycle; next state RUN.
  - pcValid goes 1 at the RUN entry edge; PCaddr is unchanged.
- RUN, iready=0: hold all registers (stall).
- RUN, iready=1: compute the target and commit on the next edge.
  - JAL: PCaddr + signExtend.
  - JALR: (rs1Read + signExtend) with bit0 cleared.
  - Branch taken conditions:
    - BEQ: Zero
    - BNE: !Zero
    - BLT: ALUneg
    - BGE: !ALUneg | Zero
    - BLTU: ALUltu
    - BGEU: !ALUltu | Zero
  - Taken branch: PCaddr + signExtend. Not taken: PCaddr + 4.
  - Every other non-error op: PCaddr + 4.
- Arithmetic: all sums are XLEN-bit and wrap modulo 2^XLEN; no overflow detection.
- Misaligned target (checked only for JAL, JALR and taken branches):
  - condition: target mod IALIGN != 0; for IALIGN=2, JALR can never fault.
  - action: enter TRAP; trapCause=01, trapValue=target, PCaddr=TRAP_VECTOR, pcValid=0.
- CU_ERROR with iready=1: enter TRAP; trapCause=10, trapValue=current PCaddr, PCaddr=TRAP_VECTOR, pcValid=0.
- TRAP:
  - trapActive=1; PCaddr, trapCause and trapValue are held.
  - iready and cuOP are ignored.
  - trapAck=1 moves to RUN on the next edge, which:
    - sets pcValid=1 and trapActive=0;
    - keeps PCaddr=TRAP_VECTOR;
    - holds trapCause and trapValue until the next trap or reset (sticky for handler readout).
  - trapAck outside TRAP is ignored.
- Latency: a new PCaddr is visible one clock after the iready-qualified edge.
- PClink is combinational from PCaddr and valid in every state.
- Branch not taken never faults, even if PCaddr + signExtend would be misaligned.

Optional Feature:
PC_PERF_COUNT_EN:
- When defined, add outputs instrCount [CNT_W] and takenCount [CNT_W].
  - instrCount increments on every RUN edge with iready=1, including the op that traps.
  - takenCount increments on every JAL, JALR or taken branch that does not trap.
  - Both counters clear on RST and wrap at 2^CNT_W.
- When undefined, neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset and boot: RST=1 for 2 cycles then 0, RESET_VECTOR=0 -> PCaddr=0, pcValid=0 for one cycle, then pcValid=1 with PCaddr still 0.
- Sequential and stall: cuOP=CU_ADD, iready=1 for 3 cycles -> PCaddr 0,4,8,12; then iready=0 for 2 cycles -> PCaddr holds 12.
- JAL and JALR: PCaddr=12, JAL, signExtend=32 -> PCaddr=44, PClink=16 before the edge. Then JALR, rs1Read=101, signExtend=4 -> PCaddr=104 (bit0 cleared).
- Branch matrix:
  - From PCaddr=0x20, signExtend=16, sweep each branch op over Zero/ALUneg/ALUltu combinations -> 0x30 when taken, 0x24 otherwise.
  - Includes BGE with ALUneg=1, Zero=1 -> taken, and BGEU with ALUltu=1, Zero=0 -> not taken.
- Misaligned trap (IALIGN=4): PCaddr=0x40, JAL, signExtend=6 ->
  - PCaddr=0x100, trapActive=1, trapCause=01, trapValue=0x46, pcValid=0;
  - held for 3 cycles with iready=1;
  - trapAck pulse -> RUN, pcValid=1, PCaddr=0x100.
- Illegal op and reset mid-trap: PCaddr=0x8, CU_ERROR -> trapCause=10, trapValue=0x8; RST asserted while in TRAP -> PCaddr=0, trapCause=00, BOOT. With PC_PERF_COUNT_EN, counters read 0 after reset.
